// File: rtl/ycbcr_to_rgb_if.sv
// ---------------------------------------------------------------------------
// ycbcr_to_rgb_if
//   Pixel stream bundle for the YCbCr->RGB converter.
//   Input side : y_in/cb_in/cr_in (8b each), in_valid, in_ready
//   Output side: r_out/g_out/b_out (8b each), out_valid, out_ready
//   modport slave  : the converter's view
//   modport master : the source/sink (testbench or neighbouring stages)
// ---------------------------------------------------------------------------
interface ycbcr_to_rgb_if;
  logic [7:0] y_in;
  logic [7:0] cb_in;
  logic [7:0] cr_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r_out;
  logic [7:0] g_out;
  logic [7:0] b_out;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  y_in, cb_in, cr_in, in_valid, out_ready,
    output in_ready, r_out, g_out, b_out, out_valid
  );

  modport master (
    output y_in, cb_in, cr_in, in_valid, out_ready,
    input  in_ready, r_out, g_out, b_out, out_valid
  );
endinterface

// File: rtl/ycbcr_to_rgb.sv
// ---------------------------------------------------------------------------
// ycbcr_to_rgb
//   3-stage pipelined BT.601 full-range YCbCr -> RGB converter, 8 bits per
//   channel, valid/ready on both sides, whole pipe stalls on backpressure.
//
//   Ports:
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : ycbcr_to_rgb_if.slave (pixel in / pixel out handshakes)
//     clip_clr  : (YCC_CLIP_CNT_EN only) synchronous clear of clip_cnt
//     clip_cnt  : (YCC_CLIP_CNT_EN only) saturating count of output
//                 pixels where any channel was clamped
//
//   Optional feature macro: YCC_CLIP_CNT_EN
//
//   Pipeline:
//     S1 latch y and the offset-removed chroma (9b signed)
//     S2 chroma products: R term, negated G term, B term (18b signed)
//     S3 per-channel sum + round + clamp, registered onto the outputs
// ---------------------------------------------------------------------------

// One colour channel of the final stage: (y<<8) + term + 128, >>>8, clamp.
module ycc_clamp_lane (
  input  logic [7:0]         i_y,
  input  logic signed [17:0] i_term,
  output logic [7:0]         o_pix
`ifdef YCC_CLIP_CNT_EN
  , output logic             o_clip
`endif
);
  logic signed [19:0] w_term20;
  logic signed [19:0] w_sum;
  logic signed [11:0] w_shr;
  logic               w_neg;
  logic               w_ovf;

  assign w_term20 = {{2{i_term[17]}}, i_term};
  assign w_sum    = $signed({4'b0000, i_y, 8'h00}) + w_term20 + 20'sd128;
  assign w_shr    = 12'(w_sum >>> 8);

  // Sign bit -> below 0; any of bits 10:8 set -> above 255.
  assign w_neg = w_shr[11];
  assign w_ovf = ~w_shr[11] & (|w_shr[10:8]);
  assign o_pix = w_neg ? 8'h00 : (w_ovf ? 8'hFF : w_shr[7:0]);

`ifdef YCC_CLIP_CNT_EN
  assign o_clip = w_neg | w_ovf;
`endif
endmodule

module ycbcr_to_rgb #(
  parameter int KR  = 359,  // 1.402 x 256
  parameter int KGB = 88,   // 0.344 x 256
  parameter int KGR = 183,  // 0.714 x 256
  parameter int KB  = 454   // 1.772 x 256
) (
  input  logic          clk,
  input  logic          rst_n,
  ycbcr_to_rgb_if.slave bus
`ifdef YCC_CLIP_CNT_EN
  , input  logic        clip_clr
  , output logic [15:0] clip_cnt
`endif
);
  localparam int STAGES = 3;
  localparam int NCH    = 3;  // lane 0 = R, 1 = G, 2 = B

  localparam logic signed [17:0] C_KR  = 18'(KR);
  localparam logic signed [17:0] C_KGB = 18'(KGB);
  localparam logic signed [17:0] C_KGR = 18'(KGR);
  localparam logic signed [17:0] C_KB  = 18'(KB);

  // vld_pipe[0] is the incoming valid, [STAGES] is out_valid.
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:1]          r_vld;
  logic                     w_en;

  logic [7:0]               r_s1_y;
  logic signed [8:0]        r_s1_cb;
  logic signed [8:0]        r_s1_cr;
  logic signed [8:0]        w_cb;
  logic signed [8:0]        w_cr;

  logic signed [17:0]       w_cb18;
  logic signed [17:0]       w_cr18;
  logic [NCH-1:0][17:0]     w_term;
  logic [7:0]               r_s2_y;
  logic [NCH-1:0][17:0]     r_s2_term;

  logic [NCH-1:0][7:0]      w_rgb;
  logic [NCH-1:0][7:0]      r_rgb;

  // Stall everything unless the output slot is empty or being drained.
  assign w_en         = bus.out_ready | ~vld_pipe[STAGES];
  assign bus.in_ready = w_en;
  assign vld_pipe     = {r_vld, bus.in_valid};

  // c - 128 for 8-bit c is c with the MSB flipped (range -128..127);
  // sign-extend to 9 bits.
  assign w_cb = {~bus.cb_in[7], ~bus.cb_in[7], bus.cb_in[6:0]};
  assign w_cr = {~bus.cr_in[7], ~bus.cr_in[7], bus.cr_in[6:0]};

  assign w_cb18 = {{9{r_s1_cb[8]}}, r_s1_cb};
  assign w_cr18 = {{9{r_s1_cr[8]}}, r_s1_cr};

  // G term is stored negated so all three lanes share one adder shape.
  assign w_term[0] = C_KR * w_cr18;
  assign w_term[1] = -((C_KGB * w_cb18) + (C_KGR * w_cr18));
  assign w_term[2] = C_KB * w_cb18;

`ifdef YCC_CLIP_CNT_EN
  logic [NCH-1:0] w_clip;
`endif

  for (genvar ln = 0; ln < NCH; ln++) begin : g_lane
    ycc_clamp_lane u_lane (
      .i_y    (r_s2_y),
      .i_term (r_s2_term[ln]),
      .o_pix  (w_rgb[ln])
`ifdef YCC_CLIP_CNT_EN
      , .o_clip (w_clip[ln])
`endif
    );
  end

  // Data registers advance on every enabled cycle, valid or not; the
  // valid bits travel alongside so bubbles stay in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      r_s1_y    <= '0;
      r_s1_cb   <= '0;
      r_s1_cr   <= '0;
      r_s2_y    <= '0;
      r_s2_term <= '0;
      r_rgb     <= '0;
    end else if (w_en) begin
      r_vld     <= vld_pipe[STAGES-1:0];
      r_s1_y    <= bus.y_in;
      r_s1_cb   <= w_cb;
      r_s1_cr   <= w_cr;
      r_s2_y    <= r_s1_y;
      r_s2_term <= w_term;
      r_rgb     <= w_rgb;
    end
  end

  assign bus.r_out     = r_rgb[0];
  assign bus.g_out     = r_rgb[1];
  assign bus.b_out     = r_rgb[2];
  assign bus.out_valid = vld_pipe[STAGES];

`ifdef YCC_CLIP_CNT_EN
  // Clip flag rides with the output pixel so it is counted exactly once,
  // at the cycle that pixel is handed off.
  logic        r_s3_clip;
  logic [15:0] r_clip_cnt;
  logic        w_out_xfer;

  assign w_out_xfer = vld_pipe[STAGES] & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_s3_clip <= 1'b0;
    else if (w_en) r_s3_clip <= |w_clip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_clip_cnt <= '0;
    else if (clip_clr)
      r_clip_cnt <= '0;
    else if (w_out_xfer && r_s3_clip && (r_clip_cnt != 16'hFFFF))
      r_clip_cnt <= r_clip_cnt + 16'd1;
  end

  assign clip_cnt = r_clip_cnt;
`endif
endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// ---------------------------------------------------------------------------
// tb_ycbcr_to_rgb
//   Scoreboard bench: the driver pushes the reference RGB of every accepted
//   pixel, a negedge monitor pops and compares on each output transfer.
// ---------------------------------------------------------------------------
module tb_ycbcr_to_rgb;
  logic clk;
  logic rst_n;
`ifdef YCC_CLIP_CNT_EN
  logic        clip_clr;
  logic [15:0] clip_cnt;
`endif

  ycbcr_to_rgb_if bus ();

  ycbcr_to_rgb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef YCC_CLIP_CNT_EN
    , .clip_clr (clip_clr)
    , .clip_cnt (clip_cnt)
`endif
  );

  typedef struct {
    logic [23:0] rgb;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference: plain integer BT.601 inverse with x256 coefficients.
  function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
    int r, g, b;
    r = sat((y * 256 + 359 * (cr - 128) + 128) / 256);
    g = sat((y * 256 - 88 * (cb - 128) - 183 * (cr - 128) + 128) / 256);
    b = sat((y * 256 + 454 * (cb - 128) + 128) / 256);
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                      input bit lat);
    int t;
    bus.y_in     = y;
    bus.cb_in    = cb;
    bus.cr_in    = cr;
    bus.in_valid = 1'b1;
    for (t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    if (t == 500) fail("send_timeout");
    else          exp_q.push_back('{ref_rgb(y, cb, cr), cyc, lat});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: an output transfer happens at the posedge after this negedge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_output");
        else begin
          e = exp_q.pop_front();
          chk("pixel", {bus.r_out, bus.g_out, bus.b_out}, e.rgb);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.y_in = 0; bus.cb_in = 0; bus.cr_in = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
`ifdef YCC_CLIP_CNT_EN
    clip_clr = 1'b0;
`endif
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rgb", {bus.r_out, bus.g_out, bus.b_out}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
`ifdef YCC_CLIP_CNT_EN
    chk("rst_clip_cnt", clip_cnt, 0);
`endif
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: grey, then the two clamp cases back to back.
    send(8'd128, 8'd128, 8'd128, 1);
    wait_drain();
    send(8'd255, 8'd128, 8'd255, 1);
    send(8'd0,   8'd128, 8'd0,   1);
    wait_drain();
`ifdef YCC_CLIP_CNT_EN
    chk("clip_cnt_two", clip_cnt, 2);
    clip_clr = 1'b1;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    chk("clip_cnt_clr", clip_cnt, 0);
`endif

    // Backpressure: 5 pixels, stall 4 cycles once the first one is out.
    fork
      begin : bp_src
        for (int i = 0; i < 5; i++)
          send(8'(20 + 45 * i), 8'(200 - 37 * i), 8'(60 + 31 * i), 0);
      end
      begin : bp_sink
        int t;
        logic [23:0] cap;
        for (t = 0; t < 50; t++) begin
          @(posedge clk); #1;
          if (bus.out_valid) break;
        end
        if (t == 50) fail("bp_first_out");
        else begin
          bus.out_ready = 1'b0;
          cap = {bus.r_out, bus.g_out, bus.b_out};
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_hold", {bus.r_out, bus.g_out, bus.b_out}, cap);
            @(posedge clk); #1;
          end
          bus.out_ready = 1'b1;
        end
      end
    join
    wait_drain();

    // Random pixels, random bubbles, random backpressure.
    done = 1'b0;
    fork
      begin : rnd_src
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 0);
        end
        done = 1'b1;
      end
      begin : rnd_sink
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with 3 pixels parked in the pipe.
    bus.out_ready = 1'b0;
    send(8'd10, 8'd20, 8'd30, 0);
    send(8'd90, 8'd140, 8'd70, 0);
    send(8'd250, 8'd5, 8'd180, 0);
    chk("flight_full", bus.out_valid, 1);
    #1; rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_rgb", {bus.r_out, bus.g_out, bus.b_out}, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(posedge clk); #2; rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_quiet", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    send(8'd40, 8'd100, 8'd200, 1);
    wait_drain();

`ifdef YCC_CLIP_CNT_EN
    for (int i = 0; i < 65540; i++) send(8'd255, 8'd128, 8'd255, 0);
    wait_drain();
    chk("clip_cnt_sat", clip_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
